// File: rtl/inv_sub_bytes_sched.sv
// Time-multiplexed InvSubBytes scheduler: round-robin arbitration between two 128-bit
// requesters, streaming the granted block LANES bytes per cycle through a shared S-box bank.
module inv_sub_bytes_sched #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r0_valid,
  input  logic [127:0]         r0_data,
  output logic                 r0_ready,
  input  logic                 r1_valid,
  input  logic [127:0]         r1_data,
  output logic                 r1_ready,
  output logic [LANES*8-1:0]   sbox_in,
  input  logic [LANES*8-1:0]   sbox_out,
  output logic                 out_valid,
  output logic                 out_id,
  output logic [127:0]         out_data,
  input  logic                 out_ready
);

  localparam int CHUNKS = 16 / LANES;
  localparam int LW     = LANES * 8;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    src_q, src_d;
  logic [127:0]    res_q, res_d;
  logic            id_q, id_d;
  logic            last_grant_q, last_grant_d;
  logic            out_valid_q, out_valid_d;
  logic            out_id_q, out_id_d;
  logic [127:0]    out_data_q, out_data_d;

  logic            grant_s;
  logic [6:0]      base_s;

  // Round-robin grant; on a tie the requester not served last wins.
  always_comb begin
    grant_s = 1'b0;
    if (r0_valid && r1_valid) begin
      grant_s = ~last_grant_q;
    end else if (r1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    r0_ready = (state_q == IDLE) && r0_valid && !grant_s;
    r1_ready = (state_q == IDLE) && r1_valid && grant_s;
  end

  // Bit offset of the current chunk; the bank input is parked at zero outside RUN.
  always_comb begin
    base_s = 7'(int'(cnt_q) * LW);
    if (state_q == RUN) begin
      sbox_in = src_q[base_s +: LW];
    end else begin
      sbox_in = '0;
    end
  end

  // Next-state logic for the scheduler FSM and its datapath registers.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    src_d        = src_q;
    res_d        = res_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_id_d     = out_id_q;
    out_data_d   = out_data_q;
    case (state_q)
      IDLE: begin
        if (r0_ready || r1_ready) begin
          src_d        = grant_s ? r1_data : r0_data;
          id_d         = grant_s;
          last_grant_d = grant_s;
          cnt_d        = '0;
          state_d      = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d[base_s +: LW] = sbox_out;
        if (cnt_q == CNT_LAST) begin
          // Publish the block including the chunk written this cycle.
          cnt_d       = '0;
          out_data_d  = res_d;
          out_id_d    = id_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      src_q        <= 128'd0;
      res_q        <= 128'd0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_id_q     <= 1'b0;
      out_data_q   <= 128'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      src_q        <= src_d;
      res_q        <= res_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_inv_sub_bytes_sched.sv
// Self-checking bench for inv_sub_bytes_sched: table-driven single requests on a LANES=4
// instance, hand-written backpressure/reset/arbitration sequences, and a LANES sweep.
module tb_inv_sub_bytes_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         r0_valid, r1_valid, r0_ready, r1_ready;
  logic [127:0] r0_data, r1_data;
  logic [31:0]  sbox_in, sbox_out;
  logic         out_valid, out_id, out_ready;
  logic [127:0] out_data;

  logic [7:0]   isb [256];

  int n_pass  = 0;
  int n_total = 0;

  // Bank model for the LANES=4 instance.
  always_comb begin
    sbox_out = '0;
    for (int b = 0; b < 4; b++) sbox_out[8*b +: 8] = isb[sbox_in[8*b +: 8]];
  end

  inv_sub_bytes_sched #(.LANES(4)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_data(r0_data), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_data(r1_data), .r1_ready(r1_ready),
    .sbox_in(sbox_in), .sbox_out(sbox_out),
    .out_valid(out_valid), .out_id(out_id), .out_data(out_data), .out_ready(out_ready)
  );

  // Sweep instances, LANES = 1, 2, 4, 8, 16.
  logic         sw_valid;
  logic [127:0] sw_data;
  logic         sw_r0r [5];
  logic         sw_r1r [5];
  logic         sw_ov  [5];
  logic         sw_oid [5];
  logic [127:0] sw_od  [5];

  for (genvar g = 0; g < 5; g++) begin : g_sw
    localparam int LN = 1 << g;
    logic [LN*8-1:0] sin, sout;
    always_comb begin
      sout = '0;
      for (int b = 0; b < LN; b++) sout[8*b +: 8] = isb[sin[8*b +: 8]];
    end
    inv_sub_bytes_sched #(.LANES(LN)) u_sw (
      .clk(clk), .rst(rst),
      .r0_valid(sw_valid), .r0_data(sw_data), .r0_ready(sw_r0r[g]),
      .r1_valid(1'b0), .r1_data(128'd0), .r1_ready(sw_r1r[g]),
      .sbox_in(sin), .sbox_out(sout),
      .out_valid(sw_ov[g]), .out_id(sw_oid[g]), .out_data(sw_od[g]), .out_ready(1'b1)
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'd0;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      hi = aa[7];
      aa = aa << 1;
      if (hi) aa = aa ^ 8'h1b;
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] v = 8'd0;
    if (x != 8'd0) begin
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'd1) v = 8'(y);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] x);
    logic [127:0] r = 128'd0;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = isb[x[8*b +: 8]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         who;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] VA     = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] VA_EXP = 128'hfbd7f3819ea340bf38a53630d56a0952;
  localparam logic [127:0] VB     = {4{32'h16017c63}};
  localparam logic [127:0] VB_EXP = {4{32'hff090100}};

  vec_t vecs [5];
  int   lat, got, cyc, last_cyc;
  int   slat [5];
  logic exp_ids [4];

  initial begin
    for (int x = 0; x < 256; x++) isb[fwd_sbox(8'(x))] = 8'(x);

    vecs[0] = '{1'b0, 128'd0, {16{8'h52}}};
    vecs[1] = '{1'b1, VB, VB_EXP};
    vecs[2] = '{1'b0, {16{8'hff}}, {16{8'h7d}}};
    vecs[3] = '{1'b1, VA, VA_EXP};
    vecs[4] = '{1'b0, {16{8'h63}}, 128'd0};
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0; r0_data = 128'd0; r1_data = 128'd0;
    out_ready = 1'b0; sw_valid = 1'b0; sw_data = 128'd0;
    tick(); tick();
    chk("reset out_valid", 128'(out_valid), 128'd0);
    chk("reset out_id", 128'(out_id), 128'd0);
    chk("reset out_data", out_data, 128'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle r0_ready", 128'(r0_ready), 128'd0);
      chk("idle r1_ready", 128'(r1_ready), 128'd0);
      chk("idle out_valid", 128'(out_valid), 128'd0);
      chk("idle out_data", out_data, 128'd0);
      chk("idle sbox_in", 128'(sbox_in), 128'd0);
    end

    // Table-driven single requests.
    for (int k = 0; k < 5; k++) begin
      r0_valid = !vecs[k].who; r1_valid = vecs[k].who;
      r0_data = vecs[k].data;  r1_data = vecs[k].data;
      #1;
      chk("vec r0_ready", 128'(r0_ready), 128'(!vecs[k].who));
      chk("vec r1_ready", 128'(r1_ready), 128'(vecs[k].who));
      tick();
      r0_valid = 1'b0; r1_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
        if (lat < 4) chk("vec sbox_in chunk", 128'(sbox_in), 128'(vecs[k].data[32*lat +: 32]));
        tick();
        lat++;
      end
      chk("vec latency", 128'(lat), 128'd4);
      chk("vec out_id", 128'(out_id), 128'(vecs[k].who));
      chk("vec out_data", out_data, vecs[k].exp);
      chk("hold sbox_in", 128'(sbox_in), 128'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("vec out_valid drop", 128'(out_valid), 128'd0);
    end

    // Backpressure: result held while both requesters wait.
    r1_valid = 1'b1; r1_data = VB;
    #1;
    chk("bp r1_ready", 128'(r1_ready), 128'd1);
    tick();
    r1_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    r0_valid = 1'b1; r0_data = VA; r1_valid = 1'b1; r1_data = VB;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("bp out_valid", 128'(out_valid), 128'd1);
      chk("bp out_data", out_data, VB_EXP);
      chk("bp out_id", 128'(out_id), 128'd1);
      chk("bp r0_ready", 128'(r0_ready), 128'd0);
      chk("bp r1_ready", 128'(r1_ready), 128'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release out_valid", 128'(out_valid), 128'd0);
    chk("bp new accept r0_ready", 128'(r0_ready), 128'd1);
    chk("bp new accept r1_ready", 128'(r1_ready), 128'd0);

    // Reset while cnt==2 of the accepted r0 block.
    tick(); tick(); tick();
    rst = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst out_valid", 128'(out_valid), 128'd0);
    chk("rst out_data", out_data, 128'd0);
    chk("rst sbox_in", 128'(sbox_in), 128'd0);
    got = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) got++;
    end
    chk("rst no output", 128'(got), 128'd0);
    r0_valid = 1'b1; r1_valid = 1'b1; r0_data = VA; r1_data = VB;
    #1;
    chk("rst tie r0_ready", 128'(r0_ready), 128'd1);
    chk("rst tie r1_ready", 128'(r1_ready), 128'd0);

    // Continuous requests from both sides: strict alternation.
    out_ready = 1'b1;
    got = 0; cyc = 0; last_cyc = 0;
    while (got < 4 && cyc < 200) begin
      tick();
      cyc++;
      chk("arb ready exclusive", 128'(r0_ready && r1_ready), 128'd0);
      if (out_valid) begin
        chk("arb out_id", 128'(out_id), 128'(exp_ids[got]));
        chk("arb out_data", out_data, out_id ? VB_EXP : VA_EXP);
        if (got > 0) chk("arb spacing", 128'(cyc - last_cyc), 128'd6);
        last_cyc = cyc;
        got++;
      end
    end
    chk("arb result count", 128'(got), 128'd4);
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    out_ready = 1'b0;

    // LANES sweep: latency equals CHUNKS.
    sw_valid = 1'b1; sw_data = VA;
    #1;
    for (int g = 0; g < 5; g++) chk("sweep r0_ready", 128'(sw_r0r[g]), 128'd1);
    tick();
    sw_valid = 1'b0;
    for (int g = 0; g < 5; g++) slat[g] = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      for (int g = 0; g < 5; g++) begin
        if (sw_ov[g] && slat[g] == 0) begin
          slat[g] = c;
          chk("sweep out_data", sw_od[g], ref_block(VA));
          chk("sweep out_id", 128'(sw_oid[g]), 128'd0);
        end
      end
    end
    for (int g = 0; g < 5; g++) chk("sweep latency", 128'(slat[g]), 128'(16 >> g));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
